// File: rtl/reflet_mem_sequencer_pkg.sv
// Shared FSM states, access size codes and the active-width helper for the
// single-port RAM sequencer.
package reflet_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] SIZE_FULL = 2'b00;
  localparam logic [1:0] SIZE_32   = 2'b01;
  localparam logic [1:0] SIZE_16   = 2'b10;
  localparam logic [1:0] SIZE_8    = 2'b11;

  // A size code only narrows the access when the word is wider than it.
  function automatic int narrow_width(input logic [1:0] size, input int wordsize);
    int w;
    w = wordsize;
    case (size)
      SIZE_FULL: w = wordsize;
      SIZE_32:   if (wordsize > 32) w = 32;
      SIZE_16:   if (wordsize > 16) w = 16;
      SIZE_8:    if (wordsize > 8) w = 8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/reflet_rr_arbiter2.sv
// Two-way round-robin arbiter: under contention the port that was not granted
// last wins; last_grant only moves when a grant is actually issued.
module reflet_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant;

  always_comb begin
    grant_valid = enable & (|req);
    grant_idx   = req[1];
    if (req == 2'b11) grant_idx = ~last_grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant <= 1'b1;
    else if (grant_valid) last_grant <= grant_idx;
  end

endmodule

// File: rtl/reflet_mem_sequencer.sv
// Shares one single-port synchronous RAM between two requesters; narrow stores
// become read-modify-write and narrow loads are zero-extended.
module reflet_mem_sequencer
  import reflet_mem_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [3:0]            size,
  input  logic [2*DATA_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [DATA_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data_out,
  output logic                  ram_write_en,
  input  logic [DATA_W-1:0]     ram_data_in
);

  state_t              state, state_nxt;
  logic                grant_valid, grant_idx;
  logic                sel_we;
  logic [1:0]          sel_size;
  logic [DATA_W-1:0]   sel_addr, sel_wdata, sel_mask;
  logic                lat_grant, lat_we, lat_narrow;
  logic [DATA_W-1:0]   lat_addr, lat_wdata, lat_mask, merge_data;

  // Ones over the bits an access of this size touches.
  function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    int w;
    w = narrow_width(sz, DATA_W);
    for (int i = 0; i < DATA_W; i++) m[i] = (i < w);
    return m;
  endfunction

  reflet_rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .enable      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we     = grant_idx ? we[1] : we[0];
  assign sel_size   = grant_idx ? size[3:2] : size[1:0];
  assign sel_addr   = grant_idx ? addr[2*DATA_W-1:DATA_W] : addr[DATA_W-1:0];
  assign sel_wdata  = grant_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  assign sel_mask   = width_mask(sel_size);
  assign lat_narrow = ~&lat_mask;
  assign busy       = (state != IDLE);

  // Request capture at grant: port inputs are ignored from here until IDLE.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      lat_grant <= grant_idx;
      lat_we    <= sel_we;
      lat_mask  <= sel_mask;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT && lat_we)
      merge_data <= (ram_data_in & ~lat_mask) | (lat_wdata & lat_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (state == WAIT && !lat_we) rdata <= ram_data_in & lat_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ram_addr     = '0;
    ram_data_out = '0;
    ram_write_en = 1'b0;
    ack          = 2'b00;
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = (sel_we && (&sel_mask)) ? WRITE : READ;
      end
      READ: begin
        ram_addr  = lat_addr;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = lat_we ? WRITE : DONE;
      end
      WRITE: begin
        ram_addr     = lat_addr;
        ram_data_out = lat_narrow ? merge_data : lat_wdata;
        ram_write_en = 1'b1;
        state_nxt    = DONE;
      end
      DONE: begin
        ack[lat_grant] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reflet_mem_sequencer.sv
// Bench for reflet_mem_sequencer: a 32-bit instance under randomized traffic
// against a transaction-level model, plus directed cases on 16- and 32-bit instances.
module tb_reflet_mem_sequencer;

  logic clk;
  logic reset;

  logic [1:0]  req32, we32, ack32;
  logic [3:0]  size32;
  logic [63:0] addr32, wdata32;
  logic [31:0] rdata32, ram_addr32, ram_do32, ram_di32;
  logic        busy32, ram_we32;

  logic [1:0]  req16, we16, ack16;
  logic [3:0]  size16;
  logic [31:0] addr16, wdata16;
  logic [15:0] rdata16, ram_addr16, ram_do16, ram_di16;
  logic        busy16, ram_we16;

  logic [31:0] mem32 [512];
  logic [15:0] mem16 [512];
  logic        bd_we32, bd_we16;
  logic [8:0]  bd_a32, bd_a16;
  logic [31:0] bd_d32;
  logic [15:0] bd_d16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // transaction-level model state for the 32-bit instance
  logic [31:0] expm [64];
  logic [1:0]  pend;
  logic        p_we [2];
  logic [1:0]  p_size [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  int          free_at, ack_cyc, rd_cyc, wr_cyc, cur_port;
  logic        cur_we, m_last;
  logic [31:0] cur_addr, wr_val, nxt_rdata, m_rdata;

  reflet_mem_sequencer #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .req(req32), .we(we32), .size(size32),
    .addr(addr32), .wdata(wdata32), .ack(ack32), .rdata(rdata32), .busy(busy32),
    .ram_addr(ram_addr32), .ram_data_out(ram_do32), .ram_write_en(ram_we32),
    .ram_data_in(ram_di32)
  );

  reflet_mem_sequencer #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .req(req16), .we(we16), .size(size16),
    .addr(addr16), .wdata(wdata16), .ack(ack16), .rdata(rdata16), .busy(busy16),
    .ram_addr(ram_addr16), .ram_data_out(ram_do16), .ram_write_en(ram_we16),
    .ram_data_in(ram_di16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we32) mem32[bd_a32] <= bd_d32;
    else if (ram_we32) mem32[ram_addr32[8:0]] <= ram_do32;
    ram_di32 <= mem32[ram_addr32[8:0]];
  end

  always @(posedge clk) begin
    if (bd_we16) mem16[bd_a16] <= bd_d16;
    else if (ram_we16) mem16[ram_addr16[8:0]] <= ram_do16;
    ram_di16 <= mem16[ram_addr16[8:0]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bd32(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_a32 = a; bd_d32 = d; bd_we32 = 1'b1;
    @(negedge clk);
    bd_we32 = 1'b0;
  endtask

  task automatic bd16(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_a16 = a; bd_d16 = d; bd_we16 = 1'b1;
    @(negedge clk);
    bd_we16 = 1'b0;
  endtask

  function automatic int model_width(input logic [1:0] s);
    if (s == 2'd3) return 8;
    if (s == 2'd2) return 16;
    return 32;
  endfunction

  // One negedge of the random phase: compare, drive masters, then arbitrate in the model.
  task automatic rand_cycle(input bit issue);
    logic [1:0]  ea;
    logic        ewe;
    logic [31:0] eaddr, edo, mask;
    int          g, nw, lat;
    ea = (cyc == ack_cyc) ? (2'b01 << cur_port) : 2'b00;
    chk("ack", 64'(ack32), 64'(ea));
    chk("busy", 64'(busy32), 64'(cyc < free_at));
    if (cyc == ack_cyc && !cur_we) m_rdata = nxt_rdata;
    chk("rdata", 64'(rdata32), 64'(m_rdata));
    ewe   = (cyc == wr_cyc);
    eaddr = (cyc == rd_cyc || ewe) ? cur_addr : 32'd0;
    edo   = ewe ? wr_val : 32'd0;
    chk("ram_write_en", 64'(ram_we32), 64'(ewe));
    chk("ram_addr", 64'(ram_addr32), 64'(eaddr));
    chk("ram_data_out", 64'(ram_do32), 64'(edo));

    for (int n = 0; n < 2; n++) begin
      if (ea[n]) begin
        pend[n] = 1'b0;
        req32[n] = 1'b0;
      end else if (cyc < free_at && cur_port == n && pend[n]) begin
        we32[n] = 1'($urandom_range(0, 1));
        size32[2*n +: 2] = 2'($urandom_range(0, 3));
        addr32[n*32 +: 32] = $urandom;
        wdata32[n*32 +: 32] = $urandom;
      end else if (!pend[n]) begin
        if (issue && $urandom_range(0, 3) == 0) begin
          pend[n] = 1'b1;
          p_we[n] = 1'($urandom_range(0, 1));
          p_size[n] = 2'($urandom_range(0, 3));
          p_addr[n] = 32'($urandom_range(0, 63));
          p_wdata[n] = $urandom;
          req32[n] = 1'b1;
          we32[n] = p_we[n];
          size32[2*n +: 2] = p_size[n];
          addr32[n*32 +: 32] = p_addr[n];
          wdata32[n*32 +: 32] = p_wdata[n];
        end else begin
          req32[n] = 1'b0;
          we32[n] = 1'($urandom_range(0, 1));
          size32[2*n +: 2] = 2'($urandom_range(0, 3));
          addr32[n*32 +: 32] = $urandom;
          wdata32[n*32 +: 32] = $urandom;
        end
      end
    end

    if (cyc >= free_at && pend != 2'b00) begin
      if (pend == 2'b11) g = m_last ? 0 : 1;
      else g = pend[1] ? 1 : 0;
      m_last   = (g == 1);
      nw       = model_width(p_size[g]);
      mask     = (nw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nw) - 32'd1);
      cur_port = g;
      cur_we   = p_we[g];
      cur_addr = p_addr[g];
      if (p_we[g] && nw == 32) begin
        lat = 2; rd_cyc = -1; wr_cyc = cyc + 1; wr_val = p_wdata[g];
      end else if (p_we[g]) begin
        lat = 4; rd_cyc = cyc + 1; wr_cyc = cyc + 3;
        wr_val = (expm[cur_addr[5:0]] & ~mask) | (p_wdata[g] & mask);
      end else begin
        lat = 3; rd_cyc = cyc + 1; wr_cyc = -1;
        nxt_rdata = expm[cur_addr[5:0]] & mask;
      end
      if (p_we[g]) expm[cur_addr[5:0]] = wr_val;
      ack_cyc = cyc + lat;
      free_at = ack_cyc + 1;
    end
    cyc++;
  endtask

  initial begin
    int strobes;
    logic [1:0] ea;
    reset = 1'b0;
    bd_we32 = 1'b0; bd_we16 = 1'b0;
    bd_a32 = '0; bd_a16 = '0; bd_d32 = '0; bd_d16 = '0;
    req32 = '0; we32 = '0; size32 = '0; addr32 = '0; wdata32 = '0;
    req16 = '0; we16 = '0; size16 = '0; addr16 = '0; wdata16 = '0;

    // reset held with random port activity
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req32 = 2'($urandom_range(0, 3)); we32 = 2'($urandom_range(0, 3));
      size32 = 4'($urandom_range(0, 15)); addr32 = {$urandom, $urandom};
      wdata32 = {$urandom, $urandom};
      req16 = 2'($urandom_range(0, 3)); we16 = 2'($urandom_range(0, 3));
      size16 = 4'($urandom_range(0, 15)); addr16 = $urandom; wdata16 = $urandom;
      #1;
      chk("rst_ack32", 64'(ack32), 64'd0);
      chk("rst_busy32", 64'(busy32), 64'd0);
      chk("rst_rdata32", 64'(rdata32), 64'd0);
      chk("rst_we32", 64'(ram_we32), 64'd0);
      chk("rst_ack16", 64'(ack16), 64'd0);
      chk("rst_busy16", 64'(busy16), 64'd0);
      chk("rst_rdata16", 64'(rdata16), 64'd0);
      chk("rst_we16", 64'(ram_we16), 64'd0);
    end
    req32 = '0; req16 = '0;

    for (int i = 0; i < 64; i++) begin
      expm[i] = $urandom;
      bd32(9'(i), expm[i]);
    end

    // randomized two-master traffic
    pend = 2'b00; free_at = 0; ack_cyc = -1; rd_cyc = -1; wr_cyc = -1;
    cur_port = 0; cur_we = 1'b0; cur_addr = '0; wr_val = '0; nxt_rdata = '0;
    m_rdata = '0; m_last = 1'b1; cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    rand_cycle(1'b1);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rand_cycle(1'b1);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rand_cycle(1'b0);
    end
    chk("drain_pending", 64'(pend), 64'd0);
    chk("drain_busy", 64'(busy32), 64'd0);
    for (int i = 0; i < 64; i++) chk("ram_word", 64'(mem32[i]), 64'(expm[i]));
    req32 = '0;

    // 32-bit narrow store: byte merged into existing word
    bd32(9'h100, 32'h1234_5678);
    @(negedge clk);
    req32 = 2'b10; we32 = 2'b10; size32 = 4'b1100;
    addr32 = {32'h0000_0100, 32'h0}; wdata32 = {32'hFFFF_FFA5, 32'h0};
    strobes = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      addr32 = {$urandom, $urandom}; wdata32 = {$urandom, $urandom};
      strobes += int'(ram_we32);
      if (k == 1) chk("t3_read_addr", 64'(ram_addr32), 64'h100);
      if (k == 3) chk("t3_write_data", 64'(ram_do32), 64'h1234_56A5);
      chk("t3_ack", 64'(ack32), (k == 4) ? 64'h2 : 64'h0);
    end
    req32 = '0;
    chk("t3_strobes", 64'(strobes), 64'd1);
    @(negedge clk);
    chk("t3_ram", 64'(mem32[9'h100]), 64'h1234_56A5);

    // reset pulsed while a narrow store waits on read data
    bd32(9'h080, 32'hAABB_CCDD);
    @(negedge clk);
    req32 = 2'b01; we32 = 2'b01; size32 = 4'b0010;
    addr32 = {32'h0, 32'h0000_0080}; wdata32 = {32'h0, 32'h0000_1234};
    @(negedge clk);
    chk("t6_read_addr", 64'(ram_addr32), 64'h80);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_busy", 64'(busy32), 64'd0);
    chk("t6_we", 64'(ram_we32), 64'd0);
    req32 = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_rst_we", 64'(ram_we32), 64'd0);
      chk("t6_rst_ack", 64'(ack32), 64'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_idle_we", 64'(ram_we32), 64'd0);
      chk("t6_idle_ack", 64'(ack32), 64'd0);
    end
    chk("t6_ram", 64'(mem32[9'h080]), 64'hAABB_CCDD);
    req32 = 2'b01; we32 = 2'b00; size32 = 4'b0000;
    addr32 = {32'h0, 32'h0000_0080};
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t6_ack", 64'(ack32), (k == 3) ? 64'h1 : 64'h0);
      if (k == 1) chk("t6_rdata_cleared", 64'(rdata32), 64'd0);
    end
    chk("t6_rdata", 64'(rdata32), 64'hAABB_CCDD);
    req32 = '0;

    // 16-bit full read
    bd16(9'h040, 16'hBEEF);
    @(negedge clk);
    req16 = 2'b01; we16 = 2'b00; size16 = 4'b0000; addr16 = 32'h0000_0040;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("t2_ram_addr", 64'(ram_addr16), 64'h40);
      chk("t2_ack", 64'(ack16), (k == 3) ? 64'h1 : 64'h0);
    end
    chk("t2_rdata", 64'(rdata16), 64'hBEEF);
    req16 = '0;

    // 16-bit store with size=01 is a full-word write, no read phase
    @(negedge clk);
    req16 = 2'b01; we16 = 2'b01; size16 = 4'b0001;
    addr16 = 32'h0000_0022; wdata16 = 32'h0000_CAFE;
    @(negedge clk);
    chk("t5_we", 64'(ram_we16), 64'd1);
    chk("t5_addr", 64'(ram_addr16), 64'h22);
    chk("t5_data", 64'(ram_do16), 64'hCAFE);
    chk("t5_ack_early", 64'(ack16), 64'd0);
    @(negedge clk);
    chk("t5_ack", 64'(ack16), 64'h1);
    req16 = '0;
    @(negedge clk);
    chk("t5_ram", 64'(mem16[9'h022]), 64'hCAFE);
    chk("t5_rdata_kept", 64'(rdata16), 64'hBEEF);

    // both ports held high from reset: grants alternate 0,1,0,1
    reset = 1'b0;
    req16 = 2'b11; we16 = 2'b00; size16 = 4'b0000;
    addr16 = {16'h0022, 16'h0040};
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ea = (k % 4 == 3) ? (((k / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("t4_ack", 64'(ack16), 64'(ea));
      if (ea == 2'b01) chk("t4_rdata0", 64'(rdata16), 64'hBEEF);
      if (ea == 2'b10) chk("t4_rdata1", 64'(rdata16), 64'hCAFE);
    end
    req16 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
